// File: rtl/quat_pkg.sv
// Shared types and constants for the sequential quaternion add/subtract unit.
package quat_pkg;

    localparam int QW = 32;
    localparam int NC = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic [QW-1:0] w;
        logic [QW-1:0] x;
        logic [QW-1:0] y;
        logic [QW-1:0] z;
    } quat_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Component index order: 0 = w, 1 = x, 2 = y, 3 = z.
    function automatic logic [QW-1:0] get_comp(input quat_t q, input logic [1:0] idx);
        logic [QW-1:0] r;
        case (idx)
            2'd0:    r = q.w;
            2'd1:    r = q.x;
            2'd2:    r = q.y;
            default: r = q.z;
        endcase
        return r;
    endfunction

    function automatic quat_t set_comp(input quat_t q, input logic [1:0] idx,
                                       input logic [QW-1:0] v);
        quat_t r;
        r = q;
        case (idx)
            2'd0:    r.w = v;
            2'd1:    r.x = v;
            2'd2:    r.y = v;
            default: r.z = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// 32-bit ripple-carry adder built from a chain of full-adder cells.
module ripple_carry_adder (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin,
    output logic [31:0] Sum,
    output logic        Cout
);

    logic [32:0] carry;

    always_comb begin
        carry    = '0;
        Sum      = '0;
        carry[0] = Cin;
        for (int unsigned i = 0; i < 32; i++) begin
            Sum[i]     = A[i] ^ B[i] ^ carry[i];
            carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
    end

    assign Cout = carry[32];

endmodule

// File: rtl/quat_addsub_seq.sv
// Sequential quaternion add/subtract: streams w,x,y,z through one 32-bit adder.
// Optional per-component signed-overflow flags are compiled in with QUAT_OVF_FLAG_EN.
module quat_addsub_seq
    import quat_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [QW*NC-1:0] in_a,
    input  logic [QW*NC-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [QW*NC-1:0] out_q,
    output logic [NC-1:0]    out_ovf
);

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    quat_t      a_q, a_d;
    quat_t      b_q, b_d;
    quat_t      res_q, res_d;
    logic       op_q, op_d;
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;

    logic [QW-1:0] add_a, add_b, add_sum;

    // Subtraction is A + ~B + 1, with the +1 supplied through Cin.
    always_comb begin
        add_a = get_comp(a_q, idx_q);
        add_b = (op_q == OP_SUB) ? ~get_comp(b_q, idx_q) : get_comp(b_q, idx_q);
    end

    ripple_carry_adder u_adder (
        .A   (add_a),
        .B   (add_b),
        .Cin (op_q),
        .Sum (add_sum),
        .Cout()
    );

`ifdef QUAT_OVF_FLAG_EN
    logic [NC-1:0] ovf_q, ovf_d;
    logic          ovf_bit;

    always_comb begin
        ovf_bit = (add_a[QW-1] == add_b[QW-1]) & (add_sum[QW-1] != add_a[QW-1]);
        ovf_d   = ovf_q;
        if (state_q == S_IDLE && in_valid) begin
            ovf_d = '0;
        end else if (state_q == S_RUN) begin
            ovf_d[2'd3 - idx_q] = ovf_bit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_q <= '0;
        else     ovf_q <= ovf_d;
    end

    assign out_ovf = ovf_q;
`else
    assign out_ovf = '0;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        op_d        = op_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d        = in_a;
                    b_d        = in_b;
                    op_d       = in_op;
                    res_d      = '0;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                res_d = set_comp(res_q, idx_q, add_sum);
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            op_q        <= OP_ADD;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            op_q        <= op_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_q     = res_q;

endmodule
